// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulator: FSM states, default widths
// and the signed 64-bit saturation bounds.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_PROD_W  = 64;
  localparam int DEF_GUARD_W = 8;
  localparam int DEF_LEN_W   = 8;

  localparam logic signed [63:0] SAT_MAX_64 = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] SAT_MIN_64 = 64'sh8000_0000_0000_0000;

endpackage

// File: rtl/mac_accumulator_if.sv
// Stream bundle for the MAC accumulator: job start, product input and result output
// valid/ready handshakes. The slave modport is the accumulator side.
interface mac_accumulator_if #(
  parameter int PROD_W  = 64,
  parameter int GUARD_W = 8,
  parameter int LEN_W   = 8
);

  logic                              start_valid;
  logic                              start_ready;
  logic [LEN_W-1:0]                  start_len;
  logic                              prod_valid;
  logic                              prod_ready;
  logic signed [PROD_W-1:0]          prod;
  logic                              res_valid;
  logic                              res_ready;
  logic signed [PROD_W+GUARD_W-1:0]  res;
  logic                              res_sat;

  modport master (
    output start_valid, start_len, prod_valid, prod, res_ready,
    input  start_ready, prod_ready, res_valid, res, res_sat
  );

  modport slave (
    input  start_valid, start_len, prod_valid, prod, res_ready,
    output start_ready, prod_ready, res_valid, res, res_sat
  );

endinterface

// File: rtl/mac_saturate.sv
// Combinational clamp of the full-width accumulator sum to the signed PROD_W range,
// returning the sign-extended clamped value and an overflow flag.
module mac_saturate
  import mac_pkg::*;
#(
  parameter int PROD_W  = DEF_PROD_W,
  parameter int GUARD_W = DEF_GUARD_W
) (
  input  logic signed [PROD_W+GUARD_W-1:0] sum,
  output logic signed [PROD_W+GUARD_W-1:0] clamped,
  output logic                             sat
);

  localparam int ACC_W = PROD_W + GUARD_W;
  localparam int TOP_W = GUARD_W + 1;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(SAT_MAX_64);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(SAT_MIN_64);

  // In range exactly when the guard bits and the PROD_W sign bit all agree.
  function automatic logic in_range(input logic signed [ACC_W-1:0] v);
    logic [TOP_W-1:0] top;
    top = v[ACC_W-1:PROD_W-1];
    return (&top) || !(|top);
  endfunction

  function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
    if (in_range(v)) return v;
    return v[ACC_W-1] ? MIN_V : MAX_V;
  endfunction

  assign clamped = clamp(sum);
  assign sat     = !in_range(sum);

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: sums start_len signed products per job into a guard-bit
// extended register and returns one result. Define MAC_ACCUMULATOR_SATURATE_EN to clamp results.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W  = DEF_PROD_W,
  parameter int GUARD_W = DEF_GUARD_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  mac_accumulator_if.slave    bus
);

  localparam int ACC_W = PROD_W + GUARD_W;

  state_t                   state;
  state_t                   state_next;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  res_next;
  logic signed [ACC_W-1:0]  res_q;
  logic [LEN_W-1:0]         remaining;
  logic                     start_fire;
  logic                     prod_fire;
  logic                     last_term;
  logic                     empty_job;

  assign start_fire = bus.start_valid && (state == IDLE);
  assign prod_fire  = bus.prod_valid && (state == ACCUM);
  assign last_term  = prod_fire && (remaining == LEN_W'(1));
  assign empty_job  = (bus.start_len == '0);
  assign sum        = acc + $signed({{GUARD_W{bus.prod[PROD_W-1]}}, bus.prod});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_fire) state_next = empty_job ? DONE : ACCUM;
      ACCUM:   if (last_term) state_next = DONE;
      DONE:    if (bus.res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Accumulation: full width, modular wrap; only the final result may be clamped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      remaining <= '0;
      res_q     <= '0;
    end else if (start_fire) begin
      acc       <= '0;
      remaining <= bus.start_len;
      if (empty_job) res_q <= '0;
    end else if (prod_fire) begin
      acc       <= sum;
      remaining <= remaining - LEN_W'(1);
      if (last_term) res_q <= res_next;
    end
  end

`ifdef MAC_ACCUMULATOR_SATURATE_EN
  logic signed [ACC_W-1:0] sum_clamped;
  logic                    sat_flag;
  logic                    res_sat_q;

  mac_saturate #(
    .PROD_W  (PROD_W),
    .GUARD_W (GUARD_W)
  ) u_saturate (
    .sum     (sum),
    .clamped (sum_clamped),
    .sat     (sat_flag)
  );

  assign res_next = sum_clamped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          res_sat_q <= 1'b0;
    else if (start_fire && empty_job) res_sat_q <= 1'b0;
    else if (last_term)               res_sat_q <= sat_flag;
  end

  assign bus.res_sat = res_sat_q;
`else
  assign res_next    = sum;
  assign bus.res_sat = 1'b0;
`endif

  assign bus.start_ready = (state == IDLE);
  assign bus.prod_ready  = (state == ACCUM);
  assign bus.res_valid   = (state == DONE);
  assign bus.res         = res_q;

endmodule
